cache_way_allocator: RTL and testbench

- Per-set way bookkeeping that sits directly upstream of the cache controller.
- Holds a valid vector and tree pseudo-LRU (PLRU) state per set.
- Drives the controller's `populated`, `populate_way` and `replace_way` inputs.
- Consumes the controller's `set`, `write_way` and `cru_enable`, plus hit information from the tag compare, to update its state one cycle later.

---
 rtl/cache_pkg.sv | 23 ++
 rtl/cache_way_allocator_plru_tree.sv | 57 +++++
 rtl/cache_way_allocator.sv | 95 +++++++++
 tb/tb_cache_way_allocator.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared cache geometry defaults, address layout and PLRU state type.
// Imported by the way allocator and its PLRU tree.
package cache_pkg;

  localparam int NUM_SETS_DEF = 16;
  localparam int NUM_WAYS_DEF = 4;
  localparam int BLOCK_SIZE   = 16;
  localparam int ADDR_W       = 32;

  localparam int SetSize    = $clog2(NUM_SETS_DEF);
  localparam int WaySize    = $clog2(NUM_WAYS_DEF);
  localparam int OffsetSize = $clog2(BLOCK_SIZE);
  localparam int TagSize    = ADDR_W - SetSize - OffsetSize;

  typedef struct packed {
    logic [TagSize-1:0]    tag;
    logic [SetSize-1:0]    set;
    logic [OffsetSize-1:0] offset;
  } cache_addr_t;

  typedef logic [NUM_WAYS_DEF-2:0] plru_bits_t;

endpackage

// File: rtl/cache_way_allocator_plru_tree.sv
// Combinational tree-PLRU: victim walk and touch update for one set.
// plru bit k holds heap node k+1 (node 1 is the root).
module plru_tree
  import cache_pkg::*;
#(
  parameter  int NUM_WAYS = NUM_WAYS_DEF,
  localparam int WW       = $clog2(NUM_WAYS)
) (
  input  logic [NUM_WAYS-2:0] plru_q,
  input  logic [WW-1:0]       access_way,
  output logic [WW-1:0]       victim,
  output logic [NUM_WAYS-2:0] plru_d
);

  logic [NUM_WAYS-1:0] tree_q;
  logic [NUM_WAYS-1:0] tree_d;
  logic                unused_pad;

  assign tree_q = {plru_q, 1'b0};

  always_comb begin
    logic [WW-1:0] n;
    logic          b;
    victim = '0;
    n      = '0;
    n[0]   = 1'b1;
    for (int l = 0; l < WW; l++) begin
      b         = tree_q[n];
      victim    = victim << 1;
      victim[0] = b;
      n         = n << 1;
      n[0]      = b;
    end
  end

  // Each node on the accessed way's path is turned away from it.
  always_comb begin
    logic [WW-1:0] n;
    logic [WW-1:0] w;
    logic          b;
    tree_d = tree_q;
    w      = access_way;
    n      = '0;
    n[0]   = 1'b1;
    for (int l = 0; l < WW; l++) begin
      b         = w[WW-1];
      tree_d[n] = ~b;
      w         = w << 1;
      n         = n << 1;
      n[0]      = b;
    end
  end

  assign plru_d     = tree_d[NUM_WAYS-1:1];
  assign unused_pad = tree_d[0];

endmodule

// File: rtl/cache_way_allocator.sv
// Per-set valid/PLRU bookkeeping feeding the cache controller.
// Optional eviction counter enabled by CACHE_ALLOC_STATS_EN.
module cache_way_allocator
  import cache_pkg::*;
#(
  parameter  int NUM_SETS = NUM_SETS_DEF,
  parameter  int NUM_WAYS = NUM_WAYS_DEF,
  localparam int SW       = $clog2(NUM_SETS),
  localparam int WW       = $clog2(NUM_WAYS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [SW-1:0] set,
  input  logic          hit,
  input  logic [WW-1:0] hit_way,
  input  logic          fill,
  input  logic [WW-1:0] fill_way,
  input  logic          cru_enable,
  input  logic          invalidate_all,
  output logic          populated,
  output logic [WW-1:0] populate_way,
  output logic [WW-1:0] replace_way,
  output logic [31:0]   evict_count
);

  logic [NUM_SETS-1:0][NUM_WAYS-1:0] valid_q;
  logic [NUM_SETS-1:0][NUM_WAYS-2:0] plru_q;

  logic [NUM_WAYS-1:0] row_valid;
  logic [NUM_WAYS-2:0] plru_nxt;
  logic [WW-1:0]       touch_way;

  assign row_valid = valid_q[set];
  assign populated = &row_valid;
  assign touch_way = fill ? fill_way : hit_way;

  always_comb begin
    populate_way = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (!row_valid[i]) populate_way = WW'(i);
    end
  end

  plru_tree #(
    .NUM_WAYS (NUM_WAYS)
  ) u_plru (
    .plru_q     (plru_q[set]),
    .access_way (touch_way),
    .victim     (replace_way),
    .plru_d     (plru_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      plru_q  <= '0;
    end else if (invalidate_all) begin
      valid_q <= '0;
      plru_q  <= '0;
    end else if (fill) begin
      valid_q[set][fill_way] <= 1'b1;
      plru_q[set]            <= plru_nxt;
    end else if (hit) begin
      plru_q[set] <= plru_nxt;
    end
  end

`ifdef CACHE_ALLOC_STATS_EN
  logic [31:0] evict_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evict_q <= '0;
    end else if (invalidate_all) begin
      evict_q <= '0;
    end else if (fill && cru_enable) begin
      evict_q <= evict_q + 32'd1;
    end
  end

  assign evict_count = evict_q;
`else
  logic unused_cru;

  assign unused_cru  = cru_enable;
  assign evict_count = '0;
`endif

  // A hit must name a way that already holds a line.
  a_hit_valid : assert property (
    @(posedge clk) disable iff (rst)
    (hit && !fill && !invalidate_all) |-> valid_q[set][hit_way]
  ) else $error("hit on invalid way");

endmodule

// File: tb/tb_cache_way_allocator.sv
// Scoreboard bench for cache_way_allocator with a range-based PLRU model.
// Evict counter expectations follow CACHE_ALLOC_STATS_EN.
module tb_cache_way_allocator;

  localparam int NS = 16;
  localparam int NW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  set;
  logic        hit;
  logic [1:0]  hit_way;
  logic        fill;
  logic [1:0]  fill_way;
  logic        cru_enable;
  logic        invalidate_all;
  logic        populated;
  logic [1:0]  populate_way;
  logic [1:0]  replace_way;
  logic [31:0] evict_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int pop;
    int pw;
    int rw;
    int ec;
    int s;
  } exp_t;

  exp_t q[$];

  bit          m_valid[NS][NW];
  bit          m_node[NS][2*NW];
  int unsigned m_cnt;

  always #5 clk = ~clk;

  cache_way_allocator #(
    .NUM_SETS (NS),
    .NUM_WAYS (NW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .set            (set),
    .hit            (hit),
    .hit_way        (hit_way),
    .fill           (fill),
    .fill_way       (fill_way),
    .cru_enable     (cru_enable),
    .invalidate_all (invalidate_all),
    .populated      (populated),
    .populate_way   (populate_way),
    .replace_way    (replace_way),
    .evict_count    (evict_count)
  );

  function automatic void m_clear();
    for (int s = 0; s < NS; s++) begin
      for (int w = 0; w < NW; w++) m_valid[s][w] = 0;
      for (int k = 0; k < 2 * NW; k++) m_node[s][k] = 0;
    end
    m_cnt = 0;
  endfunction

  // Narrow a way range by halves; each node on the way points to the other half.
  function automatic void m_touch(int s, int w);
    int lo   = 0;
    int size = NW;
    int node = 1;
    while (size > 1) begin
      int half = size / 2;
      bit up   = (w >= lo + half);
      m_node[s][node] = !up;
      node = 2 * node + (up ? 1 : 0);
      if (up) lo += half;
      size = half;
    end
  endfunction

  function automatic int m_victim(int s);
    int lo   = 0;
    int size = NW;
    int node = 1;
    while (size > 1) begin
      int half = size / 2;
      bit up   = m_node[s][node];
      node = 2 * node + (up ? 1 : 0);
      if (up) lo += half;
      size = half;
    end
    return lo;
  endfunction

  function automatic exp_t m_expect(int s);
    exp_t e;
    e.s   = s;
    e.pop = 1;
    e.pw  = 0;
    for (int w = NW - 1; w >= 0; w--) begin
      if (!m_valid[s][w]) begin
        e.pop = 0;
        e.pw  = w;
      end
    end
    e.rw = m_victim(s);
`ifdef CACHE_ALLOC_STATS_EN
    e.ec = int'(m_cnt);
`else
    e.ec = 0;
`endif
    return e;
  endfunction

  task automatic step(input int s, input int h, input int hw,
                      input int f, input int fw, input int c,
                      input int inv);
    @(posedge clk);
    #1;
    set            = 4'(s);
    hit            = (h != 0);
    hit_way        = 2'(hw);
    fill           = (f != 0);
    fill_way       = 2'(fw);
    cru_enable     = (c != 0);
    invalidate_all = (inv != 0);
    q.push_back(m_expect(s));
    if (inv != 0) begin
      m_clear();
    end else if (f != 0) begin
      m_valid[s][fw] = 1;
      m_touch(s, fw);
      if (c != 0) m_cnt++;
    end else if (h != 0) begin
      m_touch(s, hw);
    end
  endtask

  task automatic idle(input int s);
    step(s, 0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      total++;
      if (int'(populated) != e.pop) begin
        bad++;
        $display("FAIL populated set=%0d got=%0d want=%0d",
                 e.s, populated, e.pop);
      end
      total++;
      if (int'(populate_way) != e.pw) begin
        bad++;
        $display("FAIL populate_way set=%0d got=%0d want=%0d",
                 e.s, populate_way, e.pw);
      end
      total++;
      if (int'(replace_way) != e.rw) begin
        bad++;
        $display("FAIL replace_way set=%0d got=%0d want=%0d",
                 e.s, replace_way, e.rw);
      end
      total++;
      if (evict_count != 32'(e.ec)) begin
        bad++;
        $display("FAIL evict_count set=%0d got=%0d want=%0d",
                 e.s, evict_count, e.ec);
      end
    end
  end

  initial begin
    int n;
    rst            = 1'b1;
    set            = '0;
    hit            = 1'b0;
    hit_way        = '0;
    fill           = 1'b0;
    fill_way       = '0;
    cru_enable     = 1'b0;
    invalidate_all = 1'b0;
    m_clear();
    repeat (2) @(posedge clk);

    idle(3);
    @(negedge clk);
    #1 rst = 1'b0;

    for (int w = 0; w < NW; w++) step(3, 0, 0, 1, w, 1, 0);
    idle(3);
    idle(4);
    step(3, 1, 0, 0, 0, 0, 0);
    idle(3);
    step(3, 1, 2, 0, 0, 0, 0);
    idle(3);

    step(5, 1, 3, 1, 1, 0, 0);
    idle(5);

    step(6, 0, 0, 1, 0, 1, 0);
    step(6, 0, 0, 1, 1, 1, 0);
    step(6, 0, 0, 1, 2, 0, 0);
    idle(6);
    step(3, 0, 0, 0, 0, 0, 1);
    idle(3);
    idle(6);

    // Reset lands between the fill being driven and its capture edge.
    step(7, 0, 0, 1, 2, 1, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    m_clear();
    @(posedge clk);
    #2 rst = 1'b0;
    idle(7);
    idle(3);

    for (int i = 0; i < 600; i++) begin
      int s;
      int h;
      int hw;
      int f;
      int inv;
      int vw[$];
      s   = int'($urandom_range(0, 5));
      f   = ($urandom_range(0, 2) == 0) ? 1 : 0;
      inv = ($urandom_range(0, 79) == 0) ? 1 : 0;
      vw.delete();
      for (int w = 0; w < NW; w++) if (m_valid[s][w]) vw.push_back(w);
      h  = 0;
      hw = int'($urandom_range(0, NW - 1));
      if (vw.size() > 0 && $urandom_range(0, 1) == 1) begin
        h  = 1;
        hw = vw[$urandom_range(0, vw.size() - 1)];
      end
      if (f != 0 && $urandom_range(0, 1) == 1) begin
        h = 1;
      end
      step(s, h, hw, f, int'($urandom_range(0, NW - 1)),
           int'($urandom_range(0, 1)), inv);
    end
    idle(0);

    n = 0;
    while (q.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    #1;
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
